au_serial: RTL and testbench

- Parametrised, multi-cycle successor to the 1-bit arithmetic slice (`ai`, `bi`, `s0`, `s1`, `ci` -> `di`, `cil`).
- Computes a WIDTH-bit arithmetic operation LSB-first, SLICES bits per cycle, through a ripple chain of 1-bit slices and a carry flip-flop.
- Adds a valid/ready handshake on input and output, plus carry, zero and signed-overflow flags.
- Serves as the shared arithmetic engine for area-constrained datapaths.

---
 rtl/au_pkg.sv | 22 ++
 rtl/au_slice.sv | 23 ++
 rtl/au_serial.sv | 132 +++++++++++++
 tb/tb_au_serial.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/au_pkg.sv
// Shared definitions for the serial arithmetic unit.
//   - sel encodings ({s1,s0}) for the four operations
//   - FSM state type
//   - beat-count helper (cycles spent in RUN per operation)
package au_pkg;

  localparam logic [1:0] AU_XFER = 2'b00;  // D = A + cin
  localparam logic [1:0] AU_ADD  = 2'b01;  // D = A + B + cin
  localparam logic [1:0] AU_SUB  = 2'b10;  // D = A + ~B + cin
  localparam logic [1:0] AU_DEC  = 2'b11;  // D = A - 1 + cin

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } au_state_e;

  function automatic int au_beats(input int width, input int slices);
    return width / slices;
  endfunction

endpackage

// File: rtl/au_slice.sv
// Combinational 1-bit arithmetic slice.
//   ai, bi : operand bits
//   s0, s1 : operation select; the B-side term is y = (s0 & bi) | (s1 & ~bi)
//   ci     : carry in
//   di     : sum bit  = ai ^ y ^ ci
//   co     : carry out = majority(ai, y, ci)
module au_slice (
  input  logic ai,
  input  logic bi,
  input  logic s0,
  input  logic s1,
  input  logic ci,
  output logic di,
  output logic co
);

  logic y;

  assign y  = (s0 & bi) | (s1 & ~bi);
  assign di = ai ^ y ^ ci;
  assign co = (ai & y) | (ai & ci) | (y & ci);

endmodule

// File: rtl/au_serial.sv
// Multi-cycle arithmetic unit: WIDTH-bit operation computed LSB-first,
// SLICES bits per clock through a ripple chain of au_slice plus a carry flop.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE.
// in_valid outside IDLE and out_ready outside DONE are ignored.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (a, b, sel, cin sampled on accept)
//   out_valid/out_ready result handshake
//   d                   result
//   cout, zero, ovf     carry out, d == 0, signed overflow
// All outputs come from registers; no combinational input-to-output path.
module au_serial
  import au_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SLICES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       sel,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             cout,
  output logic             zero,
  output logic             ovf
);

  localparam int BEATS = au_beats(WIDTH, SLICES);
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  au_state_e        state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [1:0]       sel_r;
  logic             carry_ff;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] d_r;
  logic             cout_r;
  logic             zero_r;
  logic             ovf_r;

  // Ripple chain: c[0] is the carry held from the previous beat.
  logic [SLICES:0]   c;
  logic [SLICES-1:0] slice_d;
  logic [WIDTH-1:0]  res_next;
  logic              last_beat;

  assign c[0] = carry_ff;

  for (genvar i = 0; i < SLICES; i++) begin : g_chain
    au_slice u_slice (
      .ai (a_sr[i]),
      .bi (b_sr[i]),
      .s0 (sel_r[0]),
      .s1 (sel_r[1]),
      .ci (c[i]),
      .di (slice_d[i]),
      .co (c[i+1])
    );
  end

  // New bits enter at the MSB end; after BEATS shifts bit 0 of the result
  // has reached position 0. Written with shifts so SLICES == WIDTH works.
  assign res_next  = (res_sr >> SLICES) | (WIDTH'(slice_d) << (WIDTH - SLICES));
  assign last_beat = (count == CW'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      sel_r    <= '0;
      carry_ff <= 1'b0;
      count    <= '0;
      d_r      <= '0;
      cout_r   <= 1'b0;
      zero_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr     <= a;
            b_sr     <= b;
            sel_r    <= sel;
            carry_ff <= cin;
            count    <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sr     <= a_sr >> SLICES;
          b_sr     <= b_sr >> SLICES;
          res_sr   <= res_next;
          carry_ff <= c[SLICES];
          count    <= count + CW'(1);
          if (last_beat) begin
            // The top slice of the last beat is bit WIDTH-1.
            d_r    <= res_next;
            cout_r <= c[SLICES];
            zero_r <= (res_next == '0);
            ovf_r  <= c[SLICES] ^ c[SLICES-1];
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign d         = d_r;
  assign cout      = cout_r;
  assign zero      = zero_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_au_serial.sv
module tb_au_serial;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] sel;
    logic       cin;
    logic [7:0] d;
    logic       cout;
    logic       zero;
    logic       ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [7:0] a, b;
  logic [1:0] sel;
  logic       cin;

  // index 0: SLICES=1, 1: SLICES=4, 2: SLICES=8
  logic       in_valid_v  [3];
  logic       in_ready_v  [3];
  logic       out_valid_v [3];
  logic       out_ready_v [3];
  logic [7:0] d_v         [3];
  logic       cout_v      [3];
  logic       zero_v      [3];
  logic       ovf_v       [3];

  logic [10:0] exp_q[$];
  int passed = 0;
  int total  = 0;
  vec_t vecs[7];

  always #5 clk = ~clk;

  au_serial #(.WIDTH(8), .SLICES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a), .b(b), .sel(sel), .cin(cin), .out_valid(out_valid_v[0]),
    .out_ready(out_ready_v[0]), .d(d_v[0]), .cout(cout_v[0]), .zero(zero_v[0]),
    .ovf(ovf_v[0]));

  au_serial #(.WIDTH(8), .SLICES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a), .b(b), .sel(sel), .cin(cin), .out_valid(out_valid_v[1]),
    .out_ready(out_ready_v[1]), .d(d_v[1]), .cout(cout_v[1]), .zero(zero_v[1]),
    .ovf(ovf_v[1]));

  au_serial #(.WIDTH(8), .SLICES(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .a(a), .b(b), .sel(sel), .cin(cin), .out_valid(out_valid_v[2]),
    .out_ready(out_ready_v[2]), .d(d_v[2]), .cout(cout_v[2]), .zero(zero_v[2]),
    .ovf(ovf_v[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else
      passed++;
  endtask

  // Reference: plain 9-bit addition of A and the selected B-side term.
  function automatic logic [10:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                        input logic [1:0] ms, input logic mc);
    logic [7:0] y;
    logic [8:0] s;
    logic       v;
    case (ms)
      2'b00:   y = 8'h00;
      2'b01:   y = mb;
      2'b10:   y = ~mb;
      default: y = 8'hFF;
    endcase
    s = {1'b0, ma} + {1'b0, y} + {8'd0, mc};
    v = (ma[7] == y[7]) && (s[7] != ma[7]);
    return {s[7:0], s[8], (s[7:0] == 8'h00), v};
  endfunction

  function automatic logic [10:0] outs(input int k);
    return {d_v[k], cout_v[k], zero_v[k], ovf_v[k]};
  endfunction

  task automatic run_op(input int k, input logic [7:0] ta, input logic [7:0] tb,
                        input logic [1:0] ts, input logic tc, input logic [10:0] exp,
                        input int exp_lat, input int hold, input bit noise);
    int lat;
    logic [10:0] got;
    logic [10:0] want;
    @(negedge clk);
    check("in_ready_idle", {31'd0, in_ready_v[k]}, 32'd1);
    a = ta; b = tb; sel = ts; cin = tc;
    in_valid_v[k] = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    in_valid_v[k] = 1'b0;
    a = 8'($urandom); b = 8'($urandom); sel = 2'($urandom_range(0, 3)); cin = 1'($urandom_range(0, 1));
    lat = 0;
    while (!out_valid_v[k] && lat < 64) begin
      if (noise) begin
        in_valid_v[k] = 1'b1;
        a = 8'($urandom); b = 8'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    check("latency", lat, exp_lat);
    got = outs(k);
    for (int h = 0; h < hold; h++) begin
      if (noise) begin
        in_valid_v[k] = 1'b1;
        a = 8'($urandom); b = 8'($urandom);
      end
      @(negedge clk);
      check("hold_valid", {31'd0, out_valid_v[k]}, 32'd1);
      check("hold_in_ready", {31'd0, in_ready_v[k]}, 32'd0);
      check("hold_stable", {21'd0, outs(k)}, {21'd0, got});
    end
    out_ready_v[k] = 1'b1;
    in_valid_v[k]  = 1'b0;
    got = outs(k);
    @(posedge clk);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      want = exp_q.pop_front();
      check("result", {21'd0, got}, {21'd0, want});
    end
    @(negedge clk);
    out_ready_v[k] = 1'b0;
    check("valid_drop", {31'd0, out_valid_v[k]}, 32'd0);
    check("result_hold", {21'd0, outs(k)}, {21'd0, got});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb;
    logic [1:0] rs;
    logic       rc;
    bit         seen;

    vecs[0] = '{8'h35, 8'h4A, 2'b01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h10, 8'h10, 2'b10, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 2'b01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 2'b11, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 8'h00, 2'b00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h05, 8'h07, 2'b10, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 8'h01, 2'b10, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b1};

    // clock/reset
    rst = 1'b1; a = '0; b = '0; sel = '0; cin = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid_v[k] = 1'b0;
      out_ready_v[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", {31'd0, in_ready_v[0]}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid_v[0]}, 32'd0);
    check("rst_outputs", {21'd0, outs(0)}, 32'd0);
    check("rst_in_ready_s4", {31'd0, in_ready_v[1]}, 32'd1);
    check("rst_in_ready_s8", {31'd0, in_ready_v[2]}, 32'd1);

    // table-driven vectors; row 0 gets backpressure, row 1 gets ignored requests
    for (int i = 0; i < 7; i++) begin
      run_op(0, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].cin,
             {vecs[i].d, vecs[i].cout, vecs[i].zero, vecs[i].ovf}, 8,
             (i == 0) ? 5 : ((i == 1) ? 3 : 0), (i == 1));
    end

    // random operations against the reference
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      rs = 2'($urandom_range(0, 3)); rc = 1'($urandom_range(0, 1));
      run_op(0, ra, rb, rs, rc, model(ra, rb, rs, rc), 8, $urandom_range(0, 2), 1'b0);
    end

    // reset in the middle of RUN at count 3
    @(negedge clk);
    a = 8'h35; b = 8'h4A; sel = 2'b01; cin = 1'b0;
    in_valid_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", {31'd0, in_ready_v[0]}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid_v[0]}, 32'd0);
    check("midrst_outputs", {21'd0, outs(0)}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid_v[0]) seen = 1'b1;
    end
    check("midrst_no_result", {31'd0, seen}, 32'd0);

    // recovery after reset, then parameter sweep
    run_op(0, 8'h35, 8'h4A, 2'b01, 1'b0, model(8'h35, 8'h4A, 2'b01, 1'b0), 8, 0, 1'b0);
    run_op(1, 8'h35, 8'h4A, 2'b01, 1'b0, {8'h7F, 3'b000}, 2, 2, 1'b0);
    run_op(1, 8'h7F, 8'h01, 2'b01, 1'b0, {8'h80, 3'b001}, 2, 0, 1'b0);
    run_op(2, 8'h35, 8'h4A, 2'b01, 1'b0, {8'h7F, 3'b000}, 1, 2, 1'b0);
    run_op(2, 8'h10, 8'h10, 2'b10, 1'b1, {8'h00, 3'b110}, 1, 0, 1'b0);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
